// File: rtl/wb_regfile.sv
// Writeback-side register file: 32 x 64-bit registers with PPP byte-lane partial writes
// and two combinational read ports that see a same-cycle write through a bypass.
module wb_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        WB_wrEn,
    input  logic        WB_rD_data_select,
    input  logic [0:4]  WB_rD,
    input  logic [0:63] WB_ALU_out,
    input  logic [0:63] WB_mem_data_out,
    input  logic [0:2]  WB_ppp,
    input  logic [0:4]  ID_rA,
    input  logic [0:4]  ID_rB,
    output logic [0:63] ID_rA_data,
    output logic [0:63] ID_rB_data
);

    logic [0:63] regs_q [0:31];
    logic [0:63] regs_d [0:31];

    logic [0:63] wr_data;
    logic [0:7]  lane_mask;
    logic [0:63] bit_mask;

    always_comb begin
        wr_data = WB_rD_data_select ? WB_mem_data_out : WB_ALU_out;
    end

    // Codes 101..111 leave the mask empty, which suppresses both the write and the bypass.
    always_comb begin
        lane_mask = 8'b0000_0000;
        case (WB_ppp)
            3'b000:  lane_mask = 8'b1111_1111;
            3'b001:  lane_mask = 8'b1111_0000;
            3'b010:  lane_mask = 8'b0000_1111;
            3'b011:  lane_mask = 8'b1010_1010;
            3'b100:  lane_mask = 8'b0101_0101;
            default: lane_mask = 8'b0000_0000;
        endcase
    end

    always_comb begin
        bit_mask = '0;
        for (int k = 0; k < 8; k++) begin
            bit_mask[8*k +: 8] = {8{lane_mask[k]}};
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_d[i] = '0;
            end
        end else if (WB_wrEn) begin
            regs_d[WB_rD] = (regs_q[WB_rD] & ~bit_mask) | (wr_data & bit_mask);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Each read port resolves its own bypass, so both may hit the register being written.
    always_comb begin
        ID_rA_data = regs_q[ID_rA];
        ID_rB_data = regs_q[ID_rB];
        if (WB_wrEn && (ID_rA == WB_rD)) begin
            ID_rA_data = (regs_q[ID_rA] & ~bit_mask) | (wr_data & bit_mask);
        end
        if (WB_wrEn && (ID_rB == WB_rD)) begin
            ID_rB_data = (regs_q[ID_rB] & ~bit_mask) | (wr_data & bit_mask);
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vectors with hand-computed values,
// followed by a random regression against a lane-by-lane golden model.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        WB_wrEn;
    logic        WB_rD_data_select;
    logic [0:4]  WB_rD;
    logic [0:63] WB_ALU_out;
    logic [0:63] WB_mem_data_out;
    logic [0:2]  WB_ppp;
    logic [0:4]  ID_rA;
    logic [0:4]  ID_rB;
    logic [0:63] ID_rA_data;
    logic [0:63] ID_rB_data;

    logic [0:63] model [0:31];
    int checkCount;
    int failCount;

    wb_regfile dut (
        .clk               (clk),
        .reset             (reset),
        .WB_wrEn           (WB_wrEn),
        .WB_rD_data_select (WB_rD_data_select),
        .WB_rD             (WB_rD),
        .WB_ALU_out        (WB_ALU_out),
        .WB_mem_data_out   (WB_mem_data_out),
        .WB_ppp            (WB_ppp),
        .ID_rA             (ID_rA),
        .ID_rB             (ID_rB),
        .ID_rA_data        (ID_rA_data),
        .ID_rB_data        (ID_rB_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden merge, decided lane by lane from the PPP code.
    function automatic logic [0:63] mergeLanes(input logic [0:63] old, input logic [0:63] wd,
                                               input logic [0:2] ppp);
        logic [0:63] res;
        logic inLane;
        res = old;
        for (int k = 0; k < 8; k++) begin
            case (ppp)
                3'd0:    inLane = 1'b1;
                3'd1:    inLane = (k < 4);
                3'd2:    inLane = (k >= 4);
                3'd3:    inLane = (k % 2 == 0);
                3'd4:    inLane = (k % 2 == 1);
                default: inLane = 1'b0;
            endcase
            if (inLane) res[8*k +: 8] = wd[8*k +: 8];
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [0:63] observed,
                               input logic [0:63] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic wrEn, input logic sel,
                                 input logic [0:4] rd, input logic [0:63] alu,
                                 input logic [0:63] mem, input logic [0:2] ppp,
                                 input logic [0:4] ra, input logic [0:4] rb);
        reset             = rst;
        WB_wrEn           = wrEn;
        WB_rD_data_select = sel;
        WB_rD             = rd;
        WB_ALU_out        = alu;
        WB_mem_data_out   = mem;
        WB_ppp            = ppp;
        ID_rA             = ra;
        ID_rB             = rb;
        #2;
    endtask

    // Update the golden model from the presented inputs, then advance past the edge.
    task automatic stepClock();
        logic [0:63] wd;
        wd = WB_rD_data_select ? WB_mem_data_out : WB_ALU_out;
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (WB_wrEn) begin
            model[WB_rD] = mergeLanes(model[WB_rD], wd, WB_ppp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:63] expA;
        logic [0:63] expB;
        logic [0:63] wd;
        logic        rst;
        logic        wrEn;
        logic        sel;
        logic [0:4]  rd;
        logic [0:4]  ra;
        logic [0:4]  rb;
        logic [0:2]  ppp;
        logic [0:63] alu;
        logic [0:63] mem;

        checkCount = 0;
        failCount  = 0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 3'd0, 5'd0, 5'd0);
        stepClock();

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 3'd0, 5'(i), 5'(31 - i));
            checkOutput($sformatf("reset_rA_r%0d", i), ID_rA_data, 64'h0);
            checkOutput($sformatf("reset_rB_r%0d", 31 - i), ID_rB_data, 64'h0);
            stepClock();
        end

        // Full ALU write to r5, then partial memory writes.
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd5, 64'h0123456789ABCDEF, 64'h0, 3'd0, 5'd0, 5'd0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 3'd0, 5'd5, 5'd0);
        checkOutput("full_alu_r5", ID_rA_data, 64'h0123456789ABCDEF);
        stepClock();

        applyStimulus(1'b0, 1'b1, 1'b1, 5'd5, 64'h0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 5'd0, 5'd5);
        checkOutput("upper_bypass_rB", ID_rB_data, 64'hFFFFFFFF89ABCDEF);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 3'd0, 5'd5, 5'd0);
        checkOutput("upper_mem_r5", ID_rA_data, 64'hFFFFFFFF89ABCDEF);
        stepClock();

        applyStimulus(1'b0, 1'b1, 1'b1, 5'd5, 64'hFFFFFFFFFFFFFFFF, 64'h0, 3'd4, 5'd0, 5'd0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 3'd0, 5'd5, 5'd5);
        checkOutput("odd_zero_r5", ID_rA_data, 64'hFF00FF008900CD00);
        stepClock();

        applyStimulus(1'b0, 1'b1, 1'b0, 5'd5, 64'h0000000000000000, 64'h0, 3'd3, 5'd0, 5'd0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 3'd0, 5'd0, 5'd5);
        checkOutput("even_zero_r5", ID_rB_data, 64'h0000000000000000);
        stepClock();

        // Invalid PPP writes nothing and bypasses nothing.
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd7, 64'h1111111111111111, 64'h0, 3'd0, 5'd0, 5'd0);
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b1, 5'd7, 64'h0, 64'h2222222222222222, 3'd6, 5'd7, 5'd7);
        checkOutput("badppp_bypass_rA", ID_rA_data, 64'h1111111111111111);
        checkOutput("badppp_bypass_rB", ID_rB_data, 64'h1111111111111111);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 3'd0, 5'd7, 5'd0);
        checkOutput("badppp_store_r7", ID_rA_data, 64'h1111111111111111);
        stepClock();

        // Both ports hit the register being written in the same cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd3, 64'hAAAAAAAAAAAAAAAA, 64'h0, 3'd0, 5'd0, 5'd0);
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd3, 64'h5555555555555555, 64'h0, 3'd2, 5'd3, 5'd3);
        checkOutput("lower_bypass_rA", ID_rA_data, 64'hAAAAAAAA55555555);
        checkOutput("lower_bypass_rB", ID_rB_data, 64'hAAAAAAAA55555555);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 3'd0, 5'd3, 5'd3);
        checkOutput("lower_store_r3", ID_rA_data, 64'hAAAAAAAA55555555);
        stepClock();

        // Reset wins over a concurrent write, though the bypass still shows the write.
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd9, 64'h0F0F0F0F0F0F0F0F, 64'h0, 3'd0, 5'd0, 5'd0);
        stepClock();
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd9, 64'hDEADBEEFCAFEF00D, 64'h0, 3'd0, 5'd9, 5'd3);
        checkOutput("reset_cycle_bypass_r9", ID_rA_data, 64'hDEADBEEFCAFEF00D);
        checkOutput("reset_cycle_store_r3", ID_rB_data, 64'hAAAAAAAA55555555);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 3'd0, 5'd9, 5'd3);
        checkOutput("reset_collision_r9", ID_rA_data, 64'h0);
        checkOutput("reset_cleared_r3", ID_rB_data, 64'h0);
        stepClock();

        // Random regression over all PPP codes, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 39) == 0);
            wrEn = ($urandom_range(0, 3) != 0);
            sel  = 1'($urandom_range(0, 1));
            rd   = 5'($urandom_range(0, 7));
            ra   = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 7));
            rb   = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 7));
            ppp  = 3'($urandom_range(0, 7));
            alu  = {$urandom, $urandom};
            mem  = {$urandom, $urandom};
            wd   = sel ? mem : alu;
            expA = (wrEn && ra == rd) ? mergeLanes(model[ra], wd, ppp) : model[ra];
            expB = (wrEn && rb == rd) ? mergeLanes(model[rb], wd, ppp) : model[rb];
            applyStimulus(rst, wrEn, sel, rd, alu, mem, ppp, ra, rb);
            checkOutput($sformatf("rand%0d_rA", n), ID_rA_data, expA);
            checkOutput($sformatf("rand%0d_rB", n), ID_rB_data, expB);
            stepClock();
        end

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 3'd0, 5'(i), 5'(i));
            checkOutput($sformatf("final_r%0d", i), ID_rA_data, model[i]);
            stepClock();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
